// File: rtl/baccarat_pkg.sv
// Shared encodings and rule constants for the baccarat sequencer.
// Purely declarative: no logic, no latency, no flow control.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_EVAL1,
    S_P3,
    S_EVAL2,
    S_D3,
    S_RESULT,
    S_DONE
  } state_t;

  localparam logic [3:0] NATURAL_MIN     = 4'd8;
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;
  localparam logic [3:0] BANKER_DRAW_MAX = 4'd5;

  // Tens and face cards count as zero; rank 0 (no card) also maps to zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank >= 4'd10) ? 4'd0 : rank;
  endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// Banker third-card rule from the banker's two-card total and the player's third card.
// Combinational, zero latency; no flow control.
module banker_draw_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] i_dscore,
  input  logic [3:0] i_pcard3,
  output logic       o_draw
);

  logic [3:0] w_value;

  assign w_value = card_value(i_pcard3);

  // Totals of 7 and above (including out-of-range values) always stand.
  always_comb begin
    o_draw = 1'b0;
    case (i_dscore)
      4'd0, 4'd1, 4'd2: o_draw = 1'b1;
      4'd3:             o_draw = (w_value != 4'd8);
      4'd4:             o_draw = (w_value >= 4'd2) && (w_value <= 4'd7);
      4'd5:             o_draw = (w_value >= 4'd4) && (w_value <= 4'd7);
      4'd6:             o_draw = (w_value >= 4'd6) && (w_value <= 4'd7);
      default:          o_draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_sequencer.sv
// Moore FSM stepping the baccarat card datapath one state per slow_clock edge.
// Hand completes 7-10 cycles after reset release; no backpressure, parks in S_DONE.
module baccarat_sequencer
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       game_done
);

  state_t r_state;
  state_t w_next;
  logic   r_player_win;
  logic   r_dealer_win;
  logic   w_banker_draw;

  banker_draw_rule u_banker_draw_rule (
    .i_dscore (dscore),
    .i_pcard3 (pcard3),
    .o_draw   (w_banker_draw)
  );

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      r_state      <= S_P1;
      r_player_win <= 1'b0;
      r_dealer_win <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_RESULT) begin
        r_player_win <= (pscore >= dscore);
        r_dealer_win <= (dscore >= pscore);
      end
    end
  end

  always_comb begin
    w_next      = S_P1;
    load_pcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard1 = 1'b0;
    load_dcard2 = 1'b0;
    load_dcard3 = 1'b0;
    game_done   = 1'b0;
    case (r_state)
      S_P1: begin
        load_pcard1 = 1'b1;
        w_next      = S_D1;
      end
      S_D1: begin
        load_dcard1 = 1'b1;
        w_next      = S_P2;
      end
      S_P2: begin
        load_pcard2 = 1'b1;
        w_next      = S_D2;
      end
      S_D2: begin
        load_dcard2 = 1'b1;
        w_next      = S_EVAL1;
      end
      S_EVAL1: begin
        // Out-of-range totals fall into the natural branch via the >= compare.
        if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) begin
          w_next = S_RESULT;
        end else if (pscore <= PLAYER_DRAW_MAX) begin
          w_next = S_P3;
        end else if (dscore <= BANKER_DRAW_MAX) begin
          w_next = S_D3;
        end else begin
          w_next = S_RESULT;
        end
      end
      S_P3: begin
        load_pcard3 = 1'b1;
        w_next      = S_EVAL2;
      end
      S_EVAL2: begin
        w_next = w_banker_draw ? S_D3 : S_RESULT;
      end
      S_D3: begin
        load_dcard3 = 1'b1;
        w_next      = S_RESULT;
      end
      S_RESULT: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        game_done = 1'b1;
        w_next    = S_DONE;
      end
      default: begin
        w_next = S_P1;
      end
    endcase
  end

  assign player_win_light = r_player_win;
  assign dealer_win_light = r_dealer_win;

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Scoreboarded bench: a card datapath model feeds the sequencer, a hand-level model predicts strobes and lights.
module tb_baccarat_sequencer;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic [3:0] pscore, dscore, pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, game_done;

  always #5 slow_clock = ~slow_clock;

  baccarat_sequencer dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .game_done        (game_done)
  );

  typedef struct packed {
    logic [3:0] p1, p2, p3, d1, d2, d3, pf;
    logic       mid;
  } hand_t;

  // seq[c] is the strobe set in cycle c: bit0 p1, bit1 d1, bit2 p2, bit3 d2, bit4 p3, bit5 d3
  typedef struct packed {
    logic [15:0][5:0] seq;
    logic [4:0]       done_cyc;
    logic             pw;
    logic             dw;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Cards dealt for the current hand and an optional forced player total.
  logic [3:0] c_p1 = 0, c_p2 = 0, c_p3 = 0, c_d1 = 0, c_d2 = 0, c_d3 = 0, pf = 0;
  logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3;

  function automatic int val(input logic [3:0] r);
    return (r >= 4'd10) ? 0 : int'(r);
  endfunction

  always @(posedge slow_clock) begin
    if (!resetb) begin
      pc1 <= '0; pc2 <= '0; pc3 <= '0;
      dc1 <= '0; dc2 <= '0; dc3 <= '0;
    end else begin
      if (load_pcard1) pc1 <= c_p1;
      if (load_pcard2) pc2 <= c_p2;
      if (load_pcard3) pc3 <= c_p3;
      if (load_dcard1) dc1 <= c_d1;
      if (load_dcard2) dc2 <= c_d2;
      if (load_dcard3) dc3 <= c_d3;
    end
  end

  always_comb begin
    pscore = 4'((val(pc1) + val(pc2) + val(pc3)) % 10);
    if (pf != 4'd0) pscore = pf;
    dscore = 4'((val(dc1) + val(dc2) + val(dc3)) % 10);
    pcard3 = pc3;
  end

  // Banker tableau as masks over the player's third-card value (bit v set = draw).
  function automatic bit banker_draws(input int ds, input int v);
    logic [9:0] m;
    case (ds)
      0, 1, 2: m = 10'b11_1111_1111;
      3:       m = 10'b10_1111_1111;
      4:       m = 10'b00_1111_1100;
      5:       m = 10'b00_1111_0000;
      6:       m = 10'b00_1100_0000;
      default: m = 10'b00_0000_0000;
    endcase
    return m[v];
  endfunction

  function automatic exp_t model(input hand_t h);
    exp_t e;
    int   ps, ds, n;
    bit   nat, pdraw, bdraw;
    e = '0;
    ps = (val(h.p1) + val(h.p2)) % 10;
    ds = (val(h.d1) + val(h.d2)) % 10;
    if (h.pf != 4'd0) ps = int'(h.pf);
    e.seq[1] = 6'b000001;
    e.seq[2] = 6'b000010;
    e.seq[3] = 6'b000100;
    e.seq[4] = 6'b001000;
    n = 5;
    nat   = (ps >= 8) || (ds >= 8);
    pdraw = !nat && (ps <= 5);
    if (pdraw) begin
      n = n + 1;
      e.seq[n] = 6'b010000;
      n = n + 1;
      bdraw = banker_draws(ds, val(h.p3));
      ps = (ps + val(h.p3)) % 10;
    end else begin
      bdraw = !nat && (ds <= 5);
    end
    if (bdraw) begin
      n = n + 1;
      e.seq[n] = 6'b100000;
      ds = (ds + val(h.d3)) % 10;
    end
    n = n + 1;
    e.done_cyc = 5'(n + 1);
    e.pw = (ps >= ds);
    e.dw = (ds >= ps);
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops an expectation when game_done rises.
  initial begin
    int               cyc;
    int               rst_cnt;
    bit               done_seen;
    logic [5:0]       ld;
    logic [15:0][5:0] obs;
    exp_t             e;
    cyc = 0; rst_cnt = 0; done_seen = 1'b1; obs = '0; e = '0;
    forever begin
      @(negedge slow_clock);
      ld = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};
      if (!resetb) begin
        rst_cnt   = rst_cnt + 1;
        cyc       = 0;
        obs       = '0;
        done_seen = 1'b0;
        if (rst_cnt >= 2)
          check("reset_state", {ld, player_win_light, dealer_win_light, game_done},
                {6'b000001, 3'b000});
      end else begin
        rst_cnt = 0;
        cyc     = cyc + 1;
        check("onehot", 128'($countones(ld) <= 1), 128'(1));
        if (!done_seen) begin
          if (cyc < 16) obs[cyc] = ld;
          if (game_done) begin
            done_seen = 1'b1;
            if (exp_q.size() == 0) begin
              check("unexpected_done", 128'(cyc), 128'(0));
            end else begin
              e = exp_q.pop_front();
              check("done_cycle", 128'(cyc), 128'(e.done_cyc));
              check("load_sequence", 128'(obs), 128'(e.seq));
              check("win_lights", {player_win_light, dealer_win_light}, {e.pw, e.dw});
            end
          end else begin
            check("lights_before_done", {player_win_light, dealer_win_light}, 2'b00);
            if (cyc >= 12) begin
              check("done_timeout", 128'(cyc), 128'(0));
              done_seen = 1'b1;
              if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
          end
        end else begin
          check("done_hold", {ld, game_done, player_win_light, dealer_win_light},
                {6'b000000, 1'b1, e.pw, e.dw});
        end
      end
    end
  end

  function automatic hand_t mk(input int p1, p2, p3, d1, d2, d3, f, m);
    hand_t h;
    h.p1 = 4'(p1); h.p2 = 4'(p2); h.p3 = 4'(p3);
    h.d1 = 4'(d1); h.d2 = 4'(d2); h.d3 = 4'(d3);
    h.pf = 4'(f);  h.mid = 1'(m);
    return h;
  endfunction

  task automatic run_hand(input hand_t h);
    @(posedge slow_clock); #1 resetb = 1'b0;
    c_p1 = h.p1; c_p2 = h.p2; c_p3 = h.p3;
    c_d1 = h.d1; c_d2 = h.d2; c_d3 = h.d3;
    pf   = h.pf;
    exp_q.push_back(model(h));
    repeat (2) @(posedge slow_clock);
    #1 resetb = 1'b1;
    if (h.mid) begin
      // Abort during S_D2 with a single reset edge; the hand must replay from scratch.
      repeat (3) @(posedge slow_clock);
      #1 resetb = 1'b0;
      @(posedge slow_clock);
      #1 resetb = 1'b1;
    end
    repeat (13) @(posedge slow_clock);
  endtask

  initial begin
    hand_t dir[$];
    dir.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));   // all-zero hand
    dir.push_back(mk(3, 5, 0, 1, 2, 0, 0, 0));   // player natural 8 vs 3
    dir.push_back(mk(1, 3, 7, 2, 4, 3, 0, 0));   // both draw, dealer 9 beats 1
    dir.push_back(mk(3, 4, 0, 2, 3, 2, 0, 0));   // player stands 7, banker draws to tie
    dir.push_back(mk(1, 1, 8, 1, 2, 5, 0, 0));   // banker 3 vs third card 8: stand
    dir.push_back(mk(1, 1, 12, 2, 2, 5, 0, 0));  // banker 4 vs queen (value 0): stand
    dir.push_back(mk(1, 1, 6, 3, 3, 5, 0, 0));   // banker 6 vs 6: draw
    dir.push_back(mk(1, 1, 7, 4, 3, 5, 0, 0));   // banker 7 never draws
    dir.push_back(mk(2, 4, 0, 3, 3, 0, 0, 0));   // 6 vs 6: both stand, tie
    dir.push_back(mk(1, 3, 7, 2, 4, 3, 0, 1));   // mid-hand reset then full replay
    dir.push_back(mk(1, 1, 0, 1, 2, 0, 13, 0));  // out-of-range player total is a natural
    dir.push_back(mk(1, 1, 0, 4, 4, 0, 10, 0));
    foreach (dir[i]) run_hand(dir[i]);
    for (int i = 0; i < 40; i++) begin
      run_hand(mk($urandom_range(1, 13), $urandom_range(1, 13), $urandom_range(1, 13),
                  $urandom_range(1, 13), $urandom_range(1, 13), $urandom_range(1, 13), 0, 0));
    end
    @(negedge slow_clock);
    #1;
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
